// File: rtl/writeback_unit_if.sv
// Writeback unit bus bundle: ALU result, load issue/response handshakes,
// decode hazard query and the registered register-file write port.
// Optional macro WB_FWD_EN adds the forwarding outputs.
interface writeback_unit_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        rf_we;
`ifdef WB_FWD_EN
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [31:0] fwd_data;
`endif

    modport master (
`ifdef WB_FWD_EN
        input  fwd_rs_hit, fwd_rt_hit, fwd_data,
`endif
        output alu_valid, alu_rd, alu_wd, ld_issue, ld_issue_rd,
               resp_valid, resp_data, dec_rs, dec_rt, dec_rd,
        input  ld_issue_ready, resp_ready, hazard, rf_rd, rf_wd, rf_we
    );

    modport slave (
`ifdef WB_FWD_EN
        output fwd_rs_hit, fwd_rt_hit, fwd_data,
`endif
        input  alu_valid, alu_rd, alu_wd, ld_issue, ld_issue_rd,
               resp_valid, resp_data, dec_rs, dec_rt, dec_rd,
        output ld_issue_ready, resp_ready, hazard, rf_rd, rf_wd, rf_we
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates the single register-file write port between
// ALU results (priority) and in-order NoC load responses, tracks pending
// load destinations in a FIFO with per-register busy bits for hazards.
// Optional macro WB_FWD_EN enables the registered-write forwarding outputs.
module writeback_unit #(
    parameter int LDQ_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    writeback_unit_if.slave bus
);
    localparam int PW = $clog2(LDQ_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(LDQ_DEPTH);

    logic [4:0]    ldq [LDQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [31:0]   busy;
    logic [31:0]   busy_nxt;

    logic          issue_acc;
    logic          resp_acc;
    logic [4:0]    head_rd;
    logic          sel_valid;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_wd;

    // Handshakes, hazard query and write-port selection.
    always_comb begin
        head_rd            = ldq[rd_ptr];
        bus.ld_issue_ready = (count < DEPTH_C);
        bus.resp_ready     = !bus.alu_valid && (count != '0);
        issue_acc          = bus.ld_issue && bus.ld_issue_ready;
        resp_acc           = bus.resp_valid && bus.resp_ready;
        bus.hazard         = ((bus.dec_rs != '0) && busy[bus.dec_rs]) ||
                             ((bus.dec_rt != '0) && busy[bus.dec_rt]) ||
                             ((bus.dec_rd != '0) && busy[bus.dec_rd]);
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_wd    = '0;
        if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_wd    = bus.alu_wd;
        end else if (resp_acc) begin
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_wd    = bus.resp_data;
        end
    end

    // Busy update: clear on pop first, then set on issue so a same-cycle
    // re-issue of the popped register leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (resp_acc && (head_rd != '0)) begin
            busy_nxt[head_rd] = 1'b0;
        end
        if (issue_acc && (bus.ld_issue_rd != '0)) begin
            busy_nxt[bus.ld_issue_rd] = 1'b1;
        end
    end

    // Queue storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (issue_acc) begin
            ldq[wr_ptr] <= bus.ld_issue_rd;
        end
    end

    // Queue pointers, occupancy and busy bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
        end else begin
            busy <= busy_nxt;
            if (issue_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (resp_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (issue_acc && !resp_acc) begin
                count <= count + 1'b1;
            end else if (!issue_acc && resp_acc) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered register-file write port; destination 0 is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we <= 1'b0;
            bus.rf_rd <= '0;
            bus.rf_wd <= '0;
        end else if (sel_valid && (sel_rd != '0)) begin
            bus.rf_we <= 1'b1;
            bus.rf_rd <= sel_rd;
            bus.rf_wd <= sel_wd;
        end else begin
            bus.rf_we <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    // Forward the value currently being written to the decode stage.
    always_comb begin
        bus.fwd_rs_hit = bus.rf_we && (bus.rf_rd == bus.dec_rs) && (bus.dec_rs != '0);
        bus.fwd_rt_hit = bus.rf_we && (bus.rf_rd == bus.dec_rt) && (bus.dec_rt != '0);
        bus.fwd_data   = bus.rf_wd;
    end
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios followed by
// randomized traffic checked against a behavioural model of the queue,
// busy bits and write port.
module tb_writeback_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if bus ();
    writeback_unit #(.LDQ_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        done   = 1'b0;

    // Reference model state.
    wr_t         sb[$];
    logic [4:0]  ldq_m[$];
    logic        busy_m[32];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    wr_t         mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every expected write must appear on the cycle after issue.
    always @(negedge clk) begin
        if (!done) begin
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("rf_we", 32'(bus.rf_we), 32'd1);
                check("rf_rd", 32'(bus.rf_rd), 32'(mon_e.rd));
                check("rf_wd", bus.rf_wd, mon_e.wd);
            end else begin
                check("rf_we_idle", 32'(bus.rf_we), 32'd0);
                check("rf_rd_hold", 32'(bus.rf_rd), 32'(m_rd));
                check("rf_wd_hold", bus.rf_wd, m_wd);
            end
        end
    end

    task automatic set_inputs(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                              input logic li, input logic [4:0] lrd, input logic rv,
                              input logic [31:0] rdata, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rdd);
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_wd      = awd;
        bus.ld_issue    = li;
        bus.ld_issue_rd = lrd;
        bus.resp_valid  = rv;
        bus.resp_data   = rdata;
        bus.dec_rs      = rs;
        bus.dec_rt      = rt;
        bus.dec_rd      = rdd;
    endtask

    task automatic model_clear();
        sb.delete();
        ldq_m.delete();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        m_we = 1'b0;
        m_rd = '0;
        m_wd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        set_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 5'd10, 5'd11, 5'd1);
        model_clear();
        #1;
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
        check("rst_rf_wd", bus.rf_wd, 32'd0);
        check("rst_ld_ready", 32'(bus.ld_issue_ready), 32'd1);
        check("rst_resp_ready", 32'(bus.resp_ready), 32'd0);
        check("rst_hazard", 32'(bus.hazard), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus: apply inputs, check combinational outputs,
    // then advance the model to the state after the coming edge.
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                         input logic li, input logic [4:0] lrd, input logic rv,
                         input logic [31:0] rdata, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rdd);
        logic       exp_ir, exp_rr, exp_hz, iss, racc, wr;
        logic [4:0] head, wrd;
        logic [31:0] wwd;
        @(negedge clk);
        #1;
        set_inputs(av, ard, awd, li, lrd, rv, rdata, rs, rt, rdd);
        #1;
        exp_ir = ldq_m.size() < DEPTH;
        exp_rr = !av && (ldq_m.size() != 0);
        exp_hz = (rs != 0 && busy_m[rs]) || (rt != 0 && busy_m[rt]) || (rdd != 0 && busy_m[rdd]);
        check("ld_issue_ready", 32'(bus.ld_issue_ready), 32'(exp_ir));
        check("resp_ready", 32'(bus.resp_ready), 32'(exp_rr));
        check("hazard", 32'(bus.hazard), 32'(exp_hz));
`ifdef WB_FWD_EN
        check("fwd_rs_hit", 32'(bus.fwd_rs_hit), 32'(m_we && m_rd == rs && rs != 0));
        check("fwd_rt_hit", 32'(bus.fwd_rt_hit), 32'(m_we && m_rd == rt && rt != 0));
        check("fwd_data", bus.fwd_data, m_wd);
`endif
        iss  = li && exp_ir;
        racc = rv && exp_rr;
        head = '0;
        if (racc) head = ldq_m.pop_front();
        wr = 1'b0; wrd = '0; wwd = '0;
        if (av) begin
            wr = 1'b1; wrd = ard; wwd = awd;
        end else if (racc) begin
            wr = 1'b1; wrd = head; wwd = rdata;
        end
        if (racc && head != 0) busy_m[head] = 1'b0;
        if (iss) begin
            ldq_m.push_back(lrd);
            if (lrd != 0) busy_m[lrd] = 1'b1;
        end
        if (wr && wrd != 0) begin
            sb.push_back('{rd: wrd, wd: wwd});
            m_we = 1'b1; m_rd = wrd; m_wd = wwd;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        model_clear();
        set_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        do_reset();

        // ALU write, then idle.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 5'd5, '0, '0);
        // ALU write to r0 is suppressed.
        drive(1'b1, 5'd0, 32'h11111111, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        idle();

        // Load round trip with hazard query.
        drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, '0, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h1234, 5'd7, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 5'd7, '0, '0);

        // Contention: ALU wins, response taken next cycle.
        drive(1'b0, '0, '0, 1'b1, 5'd6, 1'b0, '0, '0, '0, '0);
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, 1'b1, 32'h55, '0, 5'd6, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h55, '0, 5'd6, '0);

        // Fill the queue, drop a fifth issue, drain in order.
        for (int i = 1; i <= 4; i++) drive(1'b0, '0, '0, 1'b1, 5'(i), 1'b0, '0, '0, '0, '0);
        drive(1'b0, '0, '0, 1'b1, 5'd5, 1'b0, '0, 5'd5, 5'd4, '0);
        for (int i = 1; i <= 4; i++) drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'(100 + i), 5'd5, 5'(i), '0);
        idle();

        // Same-cycle issue and pop of the same register: stays busy.
        drive(1'b0, '0, '0, 1'b1, 5'd2, 1'b0, '0, '0, '0, '0);
        drive(1'b0, '0, '0, 1'b1, 5'd2, 1'b1, 32'h22, '0, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 5'd2, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h23, '0, '0, 5'd2);

        // Forwarding window after an ALU write; r0 query never hits.
        drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 5'd9, '0, '0);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 5'd0, 5'd9, '0);

        // Reset with loads pending; later responses are refused.
        drive(1'b0, '0, '0, 1'b1, 5'd10, 1'b0, '0, '0, '0, '0);
        drive(1'b1, 5'd12, 32'h77, 1'b1, 5'd11, 1'b0, '0, '0, '0, '0);
        do_reset();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h99, 5'd10, 5'd11, '0);

        // Randomized traffic with one mid-run reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            drive(1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 9) < 5), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: LDQ_DEPTH, 4, pending-load queue depth (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 alu_valid  input  1  ALU result present this cycle.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_wd  input  32  ALU result data.
REQ-007 ld_issue  input  1  load issued to NoC this cycle.
REQ-008 ld_issue_rd  input  5  load destination register.
REQ-009 ld_issue_ready  output  1  queue not full; load issue accepted only when high.
REQ-010 resp_valid  input  1  NoC load response present.
REQ-011 resp_data  input  32  NoC load response data, returned in issue order.
REQ-012 resp_ready  output  1  response accepted this cycle when resp_valid is also high.
REQ-013 dec_rs, dec_rt, dec_rd  input  5 each  decode-stage register query.
REQ-014 hazard  output  1  combinational: a nonzero dec_rs/dec_rt/dec_rd has its busy bit set.
REQ-015 rf_rd  output  5  register-file write address, registered.
REQ-016 rf_wd  output  32  register-file write data, registered.
REQ-017 rf_we  output  1  register-file write enable, registered one-cycle pulse.
REQ-018 fwd_rs_hit, fwd_rt_hit  output  1 each  present only with WB_FWD_EN.
REQ-019 fwd_data  output  32  present only with WB_FWD_EN.

Function
REQ-020 Queue holds the rd of each accepted load issue in FIFO order; count 0..LDQ_DEPTH.
REQ-021 ld_issue_ready = (count < LDQ_DEPTH); ld_issue while not ready is dropped, state unchanged.
REQ-022 Accepted issue with ld_issue_rd != 0 sets busy[ld_issue_rd]; rd 0 enqueued but never busy.
REQ-023 resp_ready = !alu_valid && count != 0; ALU has strict priority for the write port.
REQ-024 Accepted response pops the queue head, clears busy[head rd], writes resp_data to head rd.
REQ-025 Issue and response accept in the same cycle: count unchanged; if issue rd equals popped rd, busy ends set (set wins).
REQ-026 Write selection: alu_valid -> (alu_rd, alu_wd); else accepted response -> (head rd, resp_data); else none.
REQ-027 Selected write registered to rf_rd/rf_wd with rf_we=1 on the next posedge: latency exactly 1 cycle.
REQ-028 Selected destination 0: rf_we=0 that cycle (write suppressed), response still consumed.
REQ-029 No selected write: rf_we=0, rf_rd/rf_wd hold previous values.
REQ-030 Queue pointers wrap modulo LDQ_DEPTH; full and empty distinguished by count.
REQ-031 alu_valid to a busy rd is a decode error; unit still performs the write, busy unchanged.

Reset
REQ-032 rst asserted: queue emptied (count 0, pointers 0), all busy bits 0, rf_we=0, rf_rd=0, rf_wd=0.
REQ-033 Reset mid-operation discards pending loads; later responses are not accepted (resp_ready=0 while empty).
REQ-034 After reset: ld_issue_ready=1, resp_ready=0, hazard=0.

Configuration
REQ-035 Macro WB_FWD_EN defined: fwd_rs_hit = rf_we && rf_rd==dec_rs && dec_rs!=0; fwd_rt_hit likewise for dec_rt; fwd_data = rf_wd; all combinational.
REQ-036 Macro WB_FWD_EN undefined: fwd_rs_hit, fwd_rt_hit, fwd_data ports and logic absent; all other behaviour identical.

Verification
REQ-037 ALU write: alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; following cycle rf_we=0.
REQ-038 Load round trip: issue rd=7 -> dec_rs=7 gives hazard=1; resp_valid=1, data=0x1234 with alu_valid=0 -> resp_ready=1, next cycle rf_we=1/rf_rd=7/rf_wd=0x1234, hazard=0.
REQ-039 Contention: alu_valid=1 (rd=3) and resp_valid=1 same cycle -> resp_ready=0, ALU written first; response accepted next cycle when alu_valid=0.
REQ-040 Full queue: 4 issues (rd 1..4) without responses -> ld_issue_ready=0, 5th issue dropped; 4 responses return rd 1,2,3,4 in order.
REQ-041 Reset mid-flight: 2 loads pending, pulse rst -> busy cleared, hazard=0, resp_ready=0, rf_we=0.
REQ-042 With WB_FWD_EN: ALU write rd=9, next cycle dec_rs=9 -> fwd_rs_hit=1, fwd_data=written value; dec_rs=0 with rf_rd=0 -> fwd_rs_hit=0.
